// File: rtl/pe_mac_if.sv
// Handshake/data bundle for one pe_mac_pipe processing element.
// The master side feeds the PE; the slave side is the PE itself.
interface pe_mac_if #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 24
);
    logic                w_load;
    logic [WEIGHT_W-1:0] w_in;
    logic [WEIGHT_W-1:0] w_out;
    logic                in_valid;
    logic [DATA_W-1:0]   x_in;
    logic [ACC_W-1:0]    y_in;
    logic                out_valid;
    logic [DATA_W-1:0]   x_out;
    logic [ACC_W-1:0]    y_out;
    logic                ovf;
    logic                ovf_clr;

    modport master (
        output w_load, w_in, in_valid, x_in, y_in, ovf_clr,
        input  w_out, out_valid, x_out, y_out, ovf
    );

    modport slave (
        input  w_load, w_in, in_valid, x_in, y_in, ovf_clr,
        output w_out, out_valid, x_out, y_out, ovf
    );
endinterface

// File: rtl/pe_mac_pipe.sv
// Pipelined systolic MAC processing element: y_out = y_in + w*x_in, x forwarded,
// both with 2-cycle latency; loadable daisy-chained weight, optional saturation.
module pe_mac_pipe #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 24,
    parameter int SAT_EN   = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    pe_mac_if.slave bus
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [WEIGHT_W-1:0] w_reg;
    logic signed [PROD_W-1:0]   prod;

    logic                       v1;
    logic signed [PROD_W-1:0]   p1;
    logic signed [ACC_W-1:0]    y1;
    logic        [DATA_W-1:0]   x1;

    logic signed [ACC_W:0]      sum;
    logic                       ovf_now;
    logic signed [ACC_W-1:0]    y_next;

    logic                       out_valid_q;
    logic        [DATA_W-1:0]   x_out_q;
    logic signed [ACC_W-1:0]    y_out_q;
    logic                       ovf_q;

    // Product width is exact, so even (-max)*(-max) cannot overflow here.
    assign prod = PROD_W'(w_reg) * PROD_W'($signed(bus.x_in));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_reg <= '0;
        end else if (bus.w_load) begin
            w_reg <= $signed(bus.w_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            p1 <= '0;
            y1 <= '0;
            x1 <= '0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                p1 <= prod;
                y1 <= $signed(bus.y_in);
                x1 <= bus.x_in;
            end
        end
    end

    // One guard bit is enough: |y1| + |p1| stays below 2^ACC_W since ACC_W >= PROD_W.
    assign sum     = {y1[ACC_W-1], y1} + {{(ACC_W+1-PROD_W){p1[PROD_W-1]}}, p1};
    assign ovf_now = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        y_next = sum[ACC_W-1:0];
        if ((SAT_EN != 0) && ovf_now) begin
            y_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= v1;
            if (v1) begin
                x_out_q <= x1;
                y_out_q <= y_next;
            end
            // A fresh overflow outranks a clear arriving on the same edge.
            if (v1 && ovf_now) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.w_out     = w_reg;
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = x_out_q;
    assign bus.y_out     = y_out_q;
    assign bus.ovf       = ovf_q;
endmodule
